snake_game_sequencer: RTL and testbench

//   Top-level controller that sequences the 8x8 snake datapath. Owns game state (INIT/PLAY/PAUSED/OVER),
//   the move-tick and LED row-scan strobes, direction latching with reverse rejection, and the score.
//   The datapath only acts on init_req/move_en, reports ate/collision, and drives LEDs from scan_row.

---
 rtl/snake_game_sequencer_if.sv | 29 ++
 rtl/snake_game_sequencer.sv | 134 +++++++++++++
 tb/tb_snake_game_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_game_sequencer_if.sv
// Control/status bundle between the snake sequencer and its datapath and panel inputs.
// master = sequencer side, slave = datapath/panel side.
interface snake_game_sequencer_if;
  logic       pause;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       ate;
  logic       collision;
  logic       move_ack;
  logic       init_req;
  logic       move_en;
  logic [1:0] move_dir;
  logic [1:0] state;
  logic [7:0] score;
  logic [2:0] scan_row;
  logic       scan_en;

  modport master (
    input  pause, up, down, left, right, ate, collision, move_ack,
    output init_req, move_en, move_dir, state, score, scan_row, scan_en
  );

  modport slave (
    output pause, up, down, left, right, ate, collision, move_ack,
    input  init_req, move_en, move_dir, state, score, scan_row, scan_en
  );
endinterface

// File: rtl/snake_game_sequencer.sv
// Single-clock game controller for the 8x8 snake: game FSM, move tick, direction latching,
// score keeping and the free-running LED row scan.
module snake_game_sequencer #(
  parameter int unsigned TICK_DIV  = 4500000,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned WIN_SCORE = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  snake_game_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    StInit   = 2'b00,
    StPlay   = 2'b01,
    StOver   = 2'b10,
    StPaused = 2'b11
  } state_e;

  localparam logic [24:0] TickLast = 25'(TICK_DIV - 1);
  localparam logic [24:0] ScanLast = 25'(SCAN_DIV - 1);
  localparam logic [7:0]  WinScore = 8'(WIN_SCORE);

  logic        pause_s1, pause_s2;
  logic [3:0]  btn_s1, btn_s2;  // {right, left, down, up}
  state_e      state_q;
  logic [1:0]  dir_q, pend_q;
  logic [7:0]  score_q;
  logic [24:0] tick_q, scan_q;
  logic [2:0]  row_q;
  logic        init_q, move_q, scan_en_q;

  logic       press_valid, press_accept, move_hit, move_lose, move_win;
  logic [1:0] press_dir;
  logic [7:0] score_inc;

  always_comb begin
    press_valid = $onehot(btn_s2);
    press_dir   = 2'd0;
    if (btn_s2[1])      press_dir = 2'd1;
    else if (btn_s2[2]) press_dir = 2'd2;
    else if (btn_s2[3]) press_dir = 2'd3;
    // Flipping bit 0 maps up<->down and left<->right.
    press_accept = press_valid && (press_dir != (dir_q ^ 2'b01));
    score_inc    = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    move_lose    = bus.move_ack & bus.collision;
    move_hit     = bus.move_ack & bus.ate & ~bus.collision;
    move_win     = move_hit && (score_inc == WinScore);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_s1 <= 1'b0;
      pause_s2 <= 1'b0;
      btn_s1   <= 4'd0;
      btn_s2   <= 4'd0;
    end else begin
      pause_s1 <= bus.pause;
      pause_s2 <= pause_s1;
      btn_s1   <= {bus.right, bus.left, bus.down, bus.up};
      btn_s2   <= btn_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      dir_q   <= 2'd0;
      pend_q  <= 2'd0;
      score_q <= 8'd0;
      tick_q  <= 25'd0;
      init_q  <= 1'b0;
      move_q  <= 1'b0;
    end else begin
      init_q <= 1'b0;
      move_q <= 1'b0;
      if (press_accept) pend_q <= press_dir;
      case (state_q)
        StInit: begin
          init_q  <= 1'b1;
          tick_q  <= 25'd0;
          score_q <= 8'd0;
          state_q <= StPlay;
        end
        StPlay, StPaused: begin
          if (move_hit) score_q <= score_inc;
          if (move_lose || move_win) begin
            state_q <= StOver;
          end else if (state_q == StPlay) begin
            if (pause_s2) begin
              state_q <= StPaused;
            end else if (tick_q == TickLast) begin
              move_q <= 1'b1;
              tick_q <= 25'd0;
              dir_q  <= pend_q;
            end else begin
              tick_q <= tick_q + 25'd1;
            end
          end else if (!pause_s2) begin
            state_q <= StPlay;  // divider resumes from its held value
          end
        end
        StOver: begin
          if (press_valid) state_q <= StInit;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q    <= 25'd0;
      row_q     <= 3'd0;
      scan_en_q <= 1'b0;
    end else if (scan_q == ScanLast) begin
      scan_q    <= 25'd0;
      row_q     <= row_q + 3'd1;
      scan_en_q <= 1'b1;
    end else begin
      scan_q    <= scan_q + 25'd1;
      scan_en_q <= 1'b0;
    end
  end

  assign bus.init_req = init_q;
  assign bus.move_en  = move_q;
  assign bus.move_dir = dir_q;
  assign bus.state    = state_q;
  assign bus.score    = score_q;
  assign bus.scan_row = row_q;
  assign bus.scan_en  = scan_en_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Self-checking bench for snake_game_sequencer: directed scenarios plus random play,
// all compared against a game-rule reference model.
module tb_snake_game_sequencer;
  localparam int TD = 4;
  localparam int SD = 2;
  localparam int WS = 3;
  localparam int S_INIT = 0, S_PLAY = 1, S_OVER = 2, S_PAUSED = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  snake_game_sequencer_if bus ();

  snake_game_sequencer #(
    .TICK_DIV (TD),
    .SCAN_DIV (SD),
    .WIN_SCORE(WS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  // Reference model state
  int m_state, m_dir, m_pend, m_score, m_tick, m_scan, m_row;
  bit m_init, m_move, m_scan_en, m_p1, m_p2;
  logic [3:0] m_b1, m_b2;

  function automatic void model_reset();
    m_state = S_INIT; m_dir = 0; m_pend = 0; m_score = 0; m_tick = 0;
    m_scan = 0; m_row = 0; m_init = 0; m_move = 0; m_scan_en = 0;
    m_p1 = 0; m_p2 = 0; m_b1 = 4'd0; m_b2 = 4'd0;
  endfunction

  task automatic model_edge();
    int  rev[4] = '{1, 0, 3, 2};
    int  d;
    int  pend_n;
    bit  valid;
    bit  done;
    valid = ($countones(m_b2) == 1);
    d = 0;
    for (int k = 0; k < 4; k++) if (m_b2[k]) d = k;
    pend_n = (valid && d != rev[m_dir]) ? d : m_pend;
    m_init = 0;
    m_move = 0;
    if (m_state == S_INIT) begin
      m_init = 1; m_tick = 0; m_score = 0; m_state = S_PLAY;
    end else if (m_state == S_OVER) begin
      if (valid) m_state = S_INIT;
    end else begin
      done = 0;
      if (bus.move_ack && bus.collision) done = 1;
      else if (bus.move_ack && bus.ate) begin
        if (m_score < 255) m_score++;
        if (m_score == WS) done = 1;
      end
      if (done) m_state = S_OVER;
      else if (m_state == S_PLAY) begin
        if (m_p2) m_state = S_PAUSED;
        else if (m_tick == TD - 1) begin
          m_move = 1; m_tick = 0; m_dir = m_pend;
        end else m_tick++;
      end else if (!m_p2) m_state = S_PLAY;
    end
    m_pend = pend_n;
    m_scan_en = 0;
    if (m_scan == SD - 1) begin
      m_scan = 0; m_row = (m_row + 1) % 8; m_scan_en = 1;
    end else m_scan++;
    m_p2 = m_p1;
    m_p1 = bus.pause;
    m_b2 = m_b1;
    m_b1 = {bus.right, bus.left, bus.down, bus.up};
  endtask

  function automatic logic [17:0] exp_vec();
    return {m_init, m_move, 2'(m_dir), 2'(m_state), 8'(m_score), 3'(m_row), m_scan_en};
  endfunction

  function automatic logic [17:0] got_vec();
    return {bus.init_req, bus.move_en, bus.move_dir, bus.state, bus.score, bus.scan_row,
            bus.scan_en};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
    bus.up = u; bus.down = d; bus.left = l; bus.right = r;
  endtask

  task automatic run_moves(input int n, output bit ok);
    int seen = 0;
    ok = 0;
    for (int i = 0; i < n * TD * 3; i++) begin
      step();
      if (bus.move_en) seen++;
      if (seen == n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_vec() !== 18'd0) begin
      errors++; $display("FAIL reset_outputs got=%h want=%h", got_vec(), 18'd0);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.init_req, bus.state} !== 3'b101) begin
      errors++; $display("FAIL init_pulse got=%b want=101", {bus.init_req, bus.state});
    end
    step();
    checks++;
    if (bus.init_req !== 1'b0) begin
      errors++; $display("FAIL init_once got=%b want=0", bus.init_req);
    end
    for (int k = 3; k <= 10; k++) begin
      step();
      checks++;
      if (bus.move_en !== 1'((k == 5) || (k == 9))) begin
        errors++; $display("FAIL tick_period edge=%0d got=%b want=%b", k, bus.move_en, (k == 5) || (k == 9));
      end
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_model got=%h want=%h", got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_direction();
    bit ok;
    logic [1:0] want [4] = '{2'd0, 2'd2, 2'd1, 2'd1};
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: set_btn(0, 1, 0, 0);
        1: set_btn(0, 0, 1, 0);
        2: set_btn(0, 1, 0, 0);
        default: set_btn(1, 0, 1, 0);
      endcase
      repeat (3) step();
      set_btn(0, 0, 0, 0);
      run_moves(2, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL dir_timeout case=%0d got=no_move want=move", t);
      end
      checks++;
      if (bus.move_dir !== want[t]) begin
        errors++; $display("FAIL dir_case%0d got=%b want=%b", t, bus.move_dir, want[t]);
      end
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL dir_model got=%h want=%h", got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_pause();
    bit ok = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (m_tick == 0 && m_state == S_PLAY) begin ok = 1; break; end
    end
    bus.pause = 1'b1;
    repeat (3) step();
    checks++;
    if (!ok || bus.state !== 2'b11) begin
      errors++; $display("FAIL pause_enter got=%b want=11", bus.state);
    end
    repeat (5) begin
      step();
      checks++;
      if (bus.move_en !== 1'b0 || bus.state !== 2'b11) begin
        errors++; $display("FAIL pause_hold got=%b/%b want=0/11", bus.move_en, bus.state);
      end
    end
    bus.pause = 1'b0;
    ok = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.state === 2'b01) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL pause_release got=%b want=01", bus.state);
    end
    step();
    checks++;
    if (bus.move_en !== 1'b0) begin
      errors++; $display("FAIL resume_early got=%b want=0", bus.move_en);
    end
    step();
    checks++;
    if (bus.move_en !== 1'b1) begin
      errors++; $display("FAIL resume_move got=%b want=1", bus.move_en);
    end
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++; $display("FAIL pause_model got=%h want=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_score_win();
    for (int i = 1; i <= 4; i++) begin
      bus.move_ack = 1'b1; bus.ate = 1'b1;
      step();
      bus.move_ack = 1'b0; bus.ate = 1'b0;
      checks++;
      if (bus.score !== 8'((i > 3) ? 3 : i)) begin
        errors++; $display("FAIL score_inc ack=%0d got=%0d want=%0d", i, bus.score, (i > 3) ? 3 : i);
      end
      checks++;
      if ((bus.state === 2'b10) !== (i >= 3)) begin
        errors++; $display("FAIL win_state ack=%0d got=%b want_over=%0d", i, bus.state, i >= 3);
      end
      step();
    end
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++; $display("FAIL win_model got=%h want=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic restart_game(input string name);
    bit ok = 0;
    set_btn(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.state === 2'b00) begin ok = 1; break; end
    end
    step();
    set_btn(0, 0, 0, 0);
    checks++;
    if (!ok || {bus.init_req, bus.state, bus.score} !== {1'b1, 2'b01, 8'd0}) begin
      errors++; $display("FAIL %s got=%b/%b/%0d want=1/01/0", name, bus.init_req, bus.state, bus.score);
    end
  endtask

  task automatic test_collision();
    restart_game("over_to_init");
    bus.move_ack = 1'b1; bus.ate = 1'b1;
    step();
    bus.move_ack = 1'b0; bus.ate = 1'b0;
    checks++;
    if (bus.score !== 8'd1) begin
      errors++; $display("FAIL coll_pre_score got=%0d want=1", bus.score);
    end
    bus.move_ack = 1'b1; bus.ate = 1'b1; bus.collision = 1'b1;
    step();
    bus.move_ack = 1'b0; bus.ate = 1'b0; bus.collision = 1'b0;
    checks++;
    if ({bus.state, bus.score} !== {2'b10, 8'd1}) begin
      errors++; $display("FAIL collision_wins got=%b/%0d want=10/1", bus.state, bus.score);
    end
    restart_game("restart_clears");
    checks++;
    if (got_vec() !== exp_vec()) begin
      errors++; $display("FAIL coll_model got=%h want=%h", got_vec(), exp_vec());
    end
  endtask

  task automatic test_scan();
    logic [2:0] prev;
    int changes = 0;
    int wraps = 0;
    prev = bus.scan_row;
    repeat (20) begin
      step();
      checks++;
      if (bus.scan_row !== (bus.scan_en ? 3'(prev + 3'd1) : prev)) begin
        errors++; $display("FAIL scan_step got=%0d want=%0d", bus.scan_row, bus.scan_en ? 3'(prev + 3'd1) : prev);
      end
      if (bus.scan_en) begin
        changes++;
        if (prev == 3'd7) wraps++;
      end
      prev = bus.scan_row;
    end
    checks++;
    if (changes != 10 || wraps < 1) begin
      errors++; $display("FAIL scan_rate got=%0d/%0d want=10/>=1", changes, wraps);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 19);
      set_btn(r == 0, r == 1, (r == 2) || (r == 4), (r == 3) || (r == 4));
      if ($urandom_range(0, 39) == 0) bus.pause = ~bus.pause;
      bus.move_ack  = ($urandom_range(0, 4) == 0);
      bus.ate       = 1'($urandom_range(0, 1));
      bus.collision = ($urandom_range(0, 5) == 0);
      step();
      checks++;
      if (got_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle %0d got=%h want=%h", i, got_vec(), exp_vec());
      end
    end
    set_btn(0, 0, 0, 0);
    bus.pause = 1'b0; bus.move_ack = 1'b0; bus.ate = 1'b0; bus.collision = 1'b0;
  endtask

  task automatic test_reset_midgame();
    repeat (7) step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (got_vec() !== 18'd0) begin
      errors++; $display("FAIL async_reset got=%h want=%h", got_vec(), 18'd0);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (got_vec() !== exp_vec() || bus.init_req !== 1'b1) begin
      errors++; $display("FAIL reset_restart got=%h want=%h", got_vec(), exp_vec());
    end
  endtask

  initial begin
    bus.pause = 1'b0; bus.move_ack = 1'b0; bus.ate = 1'b0; bus.collision = 1'b0;
    set_btn(0, 0, 0, 0);
    model_reset();
    #2;
    test_reset();
    test_direction();
    test_pause();
    test_score_win();
    test_collision();
    test_scan();
    test_random();
    test_reset_midgame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
